// File: rtl/muntjac_tl_host_arbiter.sv
// Round-robin arbiter sharing one TileLink uncached host port (A/D) between NumHosts requesters.
// Define TL_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module muntjac_tl_host_arbiter #(
  parameter int NumHosts       = 2,
  parameter int DataWidth      = 64,
  parameter int SizeWidth      = 3,
  parameter int SourceWidth    = 2,
  parameter int APayloadWidth  = 128,
  parameter int DPayloadWidth  = 72,
  localparam int IdxWidth      = $clog2(NumHosts)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,

  input  logic                            host_a_valid_i   [NumHosts],
  output logic                            host_a_ready_o   [NumHosts],
  input  logic [2:0]                      host_a_opcode_i  [NumHosts],
  input  logic [SizeWidth-1:0]            host_a_size_i    [NumHosts],
  input  logic [SourceWidth-1:0]          host_a_source_i  [NumHosts],
  input  logic [APayloadWidth-1:0]        host_a_payload_i [NumHosts],

  output logic                            dev_a_valid_o,
  input  logic                            dev_a_ready_i,
  output logic [2:0]                      dev_a_opcode_o,
  output logic [SizeWidth-1:0]            dev_a_size_o,
  output logic [SourceWidth+IdxWidth-1:0] dev_a_source_o,
  output logic [APayloadWidth-1:0]        dev_a_payload_o,

  input  logic                            dev_d_valid_i,
  output logic                            dev_d_ready_o,
  input  logic [2:0]                      dev_d_opcode_i,
  input  logic [SizeWidth-1:0]            dev_d_size_i,
  input  logic [SourceWidth+IdxWidth-1:0] dev_d_source_i,
  input  logic [DPayloadWidth-1:0]        dev_d_payload_i,

  output logic                            host_d_valid_o   [NumHosts],
  input  logic                            host_d_ready_i   [NumHosts],
  output logic [2:0]                      host_d_opcode_o  [NumHosts],
  output logic [SizeWidth-1:0]            host_d_size_o    [NumHosts],
  output logic [SourceWidth-1:0]          host_d_source_o  [NumHosts],
  output logic [DPayloadWidth-1:0]        host_d_payload_o [NumHosts]
);

  localparam int                    BeatLog  = $clog2(DataWidth / 8);
  localparam logic [SizeWidth-1:0]  BeatLogW = SizeWidth'(BeatLog);
  localparam logic [SizeWidth:0]    BeatOne  = (SizeWidth + 1)'(1);
  localparam logic [IdxWidth-1:0]   LastIdx  = IdxWidth'(NumHosts - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   grant_q, grant_d;
  logic [SizeWidth:0]    beats_left_q, beats_left_d;
`ifndef TL_ARB_FIXED_PRIO_EN
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  logic [IdxWidth-1:0]      arb_idx, cand, grant, next_idx;
  logic                     arb_found, any_grant, a_fire, multi_beat;
  logic                     sel_valid;
  logic [2:0]               sel_opcode;
  logic [SizeWidth-1:0]     sel_size;
  logic [SourceWidth-1:0]   sel_source;
  logic [APayloadWidth-1:0] sel_payload;
  logic [SizeWidth:0]       first_beats_m1;
  logic [IdxWidth-1:0]      d_idx;

  // Idle-time arbitration: pick the first requester in priority order.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
`ifdef TL_ARB_FIXED_PRIO_EN
    for (int i = NumHosts - 1; i >= 0; i--) begin
      cand = IdxWidth'(i);
      if (host_a_valid_i[i]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NumHosts; i++) begin
      cand = IdxWidth'((int'(rr_ptr_q) + i) % NumHosts);
      if (!arb_found && host_a_valid_i[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    grant       = (state_q == LOCKED) ? grant_q : arb_idx;
    any_grant   = (state_q == LOCKED) || arb_found;
    sel_valid   = 1'b0;
    sel_opcode  = '0;
    sel_size    = '0;
    sel_source  = '0;
    sel_payload = '0;
    for (int i = 0; i < NumHosts; i++) begin
      if (grant == IdxWidth'(i)) begin
        sel_valid   = host_a_valid_i[i];
        sel_opcode  = host_a_opcode_i[i];
        sel_size    = host_a_size_i[i];
        sel_source  = host_a_source_i[i];
        sel_payload = host_a_payload_i[i];
      end
    end
  end

  // Only Put messages larger than one beat lock the grant.
  assign multi_beat     = (sel_opcode == 3'd0 || sel_opcode == 3'd1) && (sel_size > BeatLogW);
  assign first_beats_m1 = (BeatOne << (sel_size - BeatLogW)) - BeatOne;
  assign next_idx       = (grant == LastIdx) ? '0 : grant + IdxWidth'(1);
  assign a_fire         = dev_a_valid_o && dev_a_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      beats_left_q <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beats_left_q <= beats_left_d;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beats_left_d = beats_left_q;
`ifndef TL_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_fire) begin
          if (multi_beat) begin
            state_d      = LOCKED;
            grant_d      = grant;
            beats_left_d = first_beats_m1;
          end else begin
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_d     = next_idx;
`endif
          end
        end
      end
      LOCKED: begin
        if (a_fire) begin
          beats_left_d = beats_left_q - BeatOne;
          if (beats_left_q == BeatOne) begin
            state_d  = IDLE;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_d = next_idx;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    dev_a_valid_o   = rst_ni && any_grant && sel_valid;
    dev_a_opcode_o  = sel_opcode;
    dev_a_size_o    = sel_size;
    dev_a_source_o  = {grant, sel_source};
    dev_a_payload_o = sel_payload;
    for (int i = 0; i < NumHosts; i++) begin
      host_a_ready_o[i] = rst_ni && any_grant && dev_a_ready_i && (grant == IdxWidth'(i));
    end
  end

  assign d_idx = dev_d_source_i[SourceWidth +: IdxWidth];

  // An index beyond NumHosts matches no host and is silently accepted.
  always_comb begin
    dev_d_ready_o = rst_ni;
    for (int i = 0; i < NumHosts; i++) begin
      host_d_valid_o[i]   = rst_ni && dev_d_valid_i && (d_idx == IdxWidth'(i));
      host_d_opcode_o[i]  = dev_d_opcode_i;
      host_d_size_o[i]    = dev_d_size_i;
      host_d_source_o[i]  = dev_d_source_i[SourceWidth-1:0];
      host_d_payload_o[i] = dev_d_payload_i;
      if (d_idx == IdxWidth'(i)) dev_d_ready_o = rst_ni && host_d_ready_i[i];
    end
  end

endmodule

// File: tb/tb_muntjac_tl_host_arbiter.sv
// Testbench for muntjac_tl_host_arbiter: directed scenarios plus random traffic checked
// against a message-level arbitration model (owner / remaining beats / next start host).
module tb_muntjac_tl_host_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid [N], a_ready [N];
  logic [2:0]   a_opcode [N], a_size [N];
  logic [1:0]   a_source [N];
  logic [127:0] a_payload [N];
  logic         dev_a_valid, dev_a_ready;
  logic [2:0]   dev_a_opcode, dev_a_size, dev_a_source;
  logic [127:0] dev_a_payload;
  logic         dev_d_valid, dev_d_ready;
  logic [2:0]   dev_d_opcode, dev_d_size, dev_d_source;
  logic [71:0]  dev_d_payload;
  logic         host_d_valid [N], host_d_ready [N];
  logic [2:0]   host_d_opcode [N], host_d_size [N];
  logic [1:0]   host_d_source [N];
  logic [71:0]  host_d_payload [N];

  // Three-host instance for modulo wrap and out-of-range D index.
  logic         a3_valid [3], a3_ready [3];
  logic [2:0]   a3_opcode [3], a3_size [3];
  logic [1:0]   a3_source [3];
  logic [127:0] a3_payload [3];
  logic         dev_a3_valid, dev_a3_ready;
  logic [2:0]   dev_a3_opcode, dev_a3_size;
  logic [3:0]   dev_a3_source;
  logic [127:0] dev_a3_payload;
  logic         dev_d3_valid, dev_d3_ready;
  logic [2:0]   dev_d3_opcode, dev_d3_size;
  logic [3:0]   dev_d3_source;
  logic [71:0]  dev_d3_payload;
  logic         host_d3_valid [3], host_d3_ready [3];
  logic [2:0]   host_d3_opcode [3], host_d3_size [3];
  logic [1:0]   host_d3_source [3];
  logic [71:0]  host_d3_payload [3];

  muntjac_tl_host_arbiter u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_a_valid_i(a_valid), .host_a_ready_o(a_ready), .host_a_opcode_i(a_opcode),
    .host_a_size_i(a_size), .host_a_source_i(a_source), .host_a_payload_i(a_payload),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready), .dev_a_opcode_o(dev_a_opcode),
    .dev_a_size_o(dev_a_size), .dev_a_source_o(dev_a_source), .dev_a_payload_o(dev_a_payload),
    .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready), .dev_d_opcode_i(dev_d_opcode),
    .dev_d_size_i(dev_d_size), .dev_d_source_i(dev_d_source), .dev_d_payload_i(dev_d_payload),
    .host_d_valid_o(host_d_valid), .host_d_ready_i(host_d_ready), .host_d_opcode_o(host_d_opcode),
    .host_d_size_o(host_d_size), .host_d_source_o(host_d_source), .host_d_payload_o(host_d_payload)
  );

  muntjac_tl_host_arbiter #(.NumHosts(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .host_a_valid_i(a3_valid), .host_a_ready_o(a3_ready), .host_a_opcode_i(a3_opcode),
    .host_a_size_i(a3_size), .host_a_source_i(a3_source), .host_a_payload_i(a3_payload),
    .dev_a_valid_o(dev_a3_valid), .dev_a_ready_i(dev_a3_ready), .dev_a_opcode_o(dev_a3_opcode),
    .dev_a_size_o(dev_a3_size), .dev_a_source_o(dev_a3_source), .dev_a_payload_o(dev_a3_payload),
    .dev_d_valid_i(dev_d3_valid), .dev_d_ready_o(dev_d3_ready), .dev_d_opcode_i(dev_d3_opcode),
    .dev_d_size_i(dev_d3_size), .dev_d_source_i(dev_d3_source), .dev_d_payload_i(dev_d3_payload),
    .host_d_valid_o(host_d3_valid), .host_d_ready_i(host_d3_ready), .host_d_opcode_o(host_d3_opcode),
    .host_d_size_o(host_d3_size), .host_d_source_o(host_d3_source), .host_d_payload_o(host_d3_payload)
  );

  int checks = 0;
  int errors = 0;
  int owner = -1;
  int owner_left = 0;
  int next_start = 0;
  int host_beats [N];
  bit random_mode = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msg_beats(input logic [2:0] op, input logic [2:0] size);
    int bytes;
    bytes = 1 << size;
    if (op <= 3'd1 && bytes > 8) return bytes / 8;
    return 1;
  endfunction

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input int h, input logic [2:0] op, input logic [2:0] size, input logic [1:0] src);
    a_valid[h]    = 1'b1;
    a_opcode[h]   = op;
    a_size[h]     = size;
    a_source[h]   = src;
    a_payload[h]  = rand_payload();
    host_beats[h] = msg_beats(op, size);
  endtask

  task automatic model_grant(output int g, output bit any);
    g   = 0;
    any = 1'b0;
    if (owner >= 0) begin
      g   = owner;
      any = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int h;
        h = (next_start + k) % N;
        if (!any && a_valid[h]) begin
          g   = h;
          any = 1'b1;
        end
      end
    end
  endtask

  task automatic release_to(input int g);
`ifndef TL_ARB_FIXED_PRIO_EN
    next_start = (g + 1) % N;
`endif
    owner = -1;
  endtask

  task automatic model_accept(input int g);
    int b;
    if (owner < 0) begin
      b = msg_beats(a_opcode[g], a_size[g]);
      if (b > 1) begin
        owner      = g;
        owner_left = b - 1;
      end else begin
        release_to(g);
      end
    end else begin
      owner_left--;
      if (owner_left == 0) release_to(g);
    end
  endtask

  task automatic randomize_inputs();
    dev_a_ready   = ($urandom_range(0, 3) != 0);
    dev_d_valid   = 1'($urandom);
    dev_d_opcode  = 3'($urandom);
    dev_d_size    = 3'($urandom);
    dev_d_source  = 3'($urandom);
    dev_d_payload = 72'({$urandom, $urandom, $urandom});
    for (int h = 0; h < N; h++) begin
      host_d_ready[h] = 1'($urandom);
      if (!a_valid[h] && $urandom_range(0, 1) == 1)
        issue(h, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)), 2'($urandom));
    end
  endtask

  // Compare every output of the two-host instance now, then advance one clock.
  task automatic step(input string tag);
    int   g, didx;
    bit   any;
    logic exp_v, fire;
    model_grant(g, any);
    exp_v = any && a_valid[g];
    check($sformatf("%s dev_a_valid", tag), 128'(dev_a_valid), 128'(exp_v));
    if (exp_v) begin
      check($sformatf("%s dev_a_opcode", tag), 128'(dev_a_opcode), 128'(a_opcode[g]));
      check($sformatf("%s dev_a_size", tag), 128'(dev_a_size), 128'(a_size[g]));
      check($sformatf("%s dev_a_source", tag), 128'(dev_a_source), 128'(g * 4 + int'(a_source[g])));
      check($sformatf("%s dev_a_payload", tag), dev_a_payload, a_payload[g]);
    end
    for (int i = 0; i < N; i++)
      check($sformatf("%s host_a_ready%0d", tag, i), 128'(a_ready[i]), 128'(dev_a_ready && any && g == i));
    didx = int'(dev_d_source[2]);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s host_d_valid%0d", tag, i), 128'(host_d_valid[i]), 128'(dev_d_valid && didx == i));
      check($sformatf("%s host_d_source%0d", tag, i), 128'(host_d_source[i]), 128'(dev_d_source[1:0]));
      check($sformatf("%s host_d_opcode%0d", tag, i), 128'(host_d_opcode[i]), 128'(dev_d_opcode));
      check($sformatf("%s host_d_size%0d", tag, i), 128'(host_d_size[i]), 128'(dev_d_size));
      check($sformatf("%s host_d_payload%0d", tag, i), 128'(host_d_payload[i]), 128'(dev_d_payload));
    end
    check($sformatf("%s dev_d_ready", tag), 128'(dev_d_ready), 128'(host_d_ready[didx]));
    fire = exp_v && dev_a_ready;
    @(posedge clk);
    #1;
    if (fire) begin
      model_accept(g);
      host_beats[g]--;
      if (host_beats[g] == 0) a_valid[g] = 1'b0;
      else a_payload[g] = rand_payload();
    end
    if (random_mode) randomize_inputs();
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    step(tag);
  endtask

  initial begin
    logic [127:0] held;
    int exp_g;
    for (int i = 0; i < N; i++) begin
      a_valid[i] = 1'b0; a_opcode[i] = '0; a_size[i] = '0; a_source[i] = '0; a_payload[i] = '0;
      host_beats[i] = 0; host_d_ready[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      a3_valid[i] = 1'b0; a3_opcode[i] = 3'd4; a3_size[i] = 3'd3; a3_source[i] = 2'(i);
      a3_payload[i] = 128'(i); host_d3_ready[i] = 1'b1;
    end
    dev_a_ready = 1'b1; dev_d_valid = 1'b1; dev_d_opcode = 3'd1; dev_d_size = 3'd3;
    dev_d_source = 3'b100; dev_d_payload = '0;
    dev_a3_ready = 1'b1; dev_d3_valid = 1'b0; dev_d3_opcode = '0; dev_d3_size = '0;
    dev_d3_source = '0; dev_d3_payload = '0;

    // Reset: handshakes forced low even with requests pending.
    #1 rst_n = 1'b0;
    issue(0, 3'd4, 3'd3, 2'd1);
    issue(1, 3'd4, 3'd3, 2'd2);
    #1;
    check("rst dev_a_valid", 128'(dev_a_valid), 128'(0));
    check("rst host_a_ready0", 128'(a_ready[0]), 128'(0));
    check("rst host_a_ready1", 128'(a_ready[1]), 128'(0));
    check("rst host_d_valid1", 128'(host_d_valid[1]), 128'(0));
    check("rst dev_d_ready", 128'(dev_d_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    dev_d_valid = 1'b0;

    // Two Gets from reset: host0 then host1.
    @(negedge clk);
    check("get0 source", 128'(dev_a_source), 128'(3'b001));
    step("get0");
    @(negedge clk);
    check("get1 source", 128'(dev_a_source), 128'(3'b110));
    step("get1");

    // Burst locking: host0 shows up during host1's 4-beat PutFullData.
    issue(1, 3'd0, 3'd5, 2'd3);
    cycle("lock b1");
    issue(0, 3'd4, 3'd3, 2'd0);
    for (int b = 2; b <= 4; b++) begin
      @(negedge clk);
      check($sformatf("lock b%0d host0 ready", b), 128'(a_ready[0]), 128'(0));
      step($sformatf("lock b%0d", b));
    end
    @(negedge clk);
    check("lock after source", 128'(dev_a_source), 128'(3'b000));
    step("lock after");

    // Device stall during beat 2 of 4; host0 waits behind the burst.
    issue(1, 3'd0, 3'd5, 2'd1);
    cycle("stall b1");
    issue(0, 3'd4, 3'd3, 2'd2);
    dev_a_ready = 1'b0;
    held = a_payload[1];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall payload", dev_a_payload, held);
      check("stall source", 128'(dev_a_source), 128'(3'b101));
      step("stall");
    end
    dev_a_ready = 1'b1;
    for (int b = 2; b <= 4; b++) cycle($sformatf("stall b%0d", b));
    @(negedge clk);
    check("stall after source", 128'(dev_a_source), 128'(3'b010));
    step("stall after");

    // D routing: source 3'b111 addresses host1.
    dev_d_valid = 1'b1; dev_d_source = 3'b111; dev_d_payload = 72'h5A_1234_5678_9ABC_DEF0;
    host_d_ready[0] = 1'b1; host_d_ready[1] = 1'b0;
    @(negedge clk);
    check("d host_d_valid1", 128'(host_d_valid[1]), 128'(1));
    check("d host_d_valid0", 128'(host_d_valid[0]), 128'(0));
    check("d host_d_source1", 128'(host_d_source[1]), 128'(2'b11));
    check("d dev_d_ready wait", 128'(dev_d_ready), 128'(0));
    step("d wait");
    host_d_ready[1] = 1'b1;
    @(negedge clk);
    check("d dev_d_ready go", 128'(dev_d_ready), 128'(1));
    step("d go");
    dev_d_valid = 1'b0;

    // Reset in the middle of a burst aborts the lock.
    issue(1, 3'd0, 3'd5, 2'd2);
    cycle("rstb b1");
    cycle("rstb b2");
    dev_d_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstb dev_a_valid", 128'(dev_a_valid), 128'(0));
    check("rstb host_a_ready1", 128'(a_ready[1]), 128'(0));
    check("rstb host_d_valid1", 128'(host_d_valid[1]), 128'(0));
    check("rstb dev_d_ready", 128'(dev_d_ready), 128'(0));
    owner = -1; owner_left = 0; next_start = 0;
    a_valid[1] = 1'b0; host_beats[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dev_d_valid = 1'b0;
    issue(1, 3'd4, 3'd2, 2'd3);
    @(negedge clk);
    check("rstb get valid", 128'(dev_a_valid), 128'(1));
    check("rstb get source", 128'(dev_a_source), 128'(3'b111));
    step("rstb get");

    // Host0 back-to-back Gets with host1 always requesting.
    issue(0, 3'd4, 3'd3, 2'd0);
    issue(1, 3'd4, 3'd3, 2'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      @(negedge clk);
      check($sformatf("alt%0d grant", k), 128'(dev_a_source[2]), 128'(exp_g));
      step($sformatf("alt%0d", k));
      if (!a_valid[0]) issue(0, 3'd4, 3'd3, 2'd0);
      if (!a_valid[1]) issue(1, 3'd4, 3'd3, 2'd1);
    end
    a_valid[0] = 1'b0; a_valid[1] = 1'b0; host_beats[0] = 0; host_beats[1] = 0;
    owner = -1; owner_left = 0;
    cycle("quiet");

    // Three hosts: rotation wraps modulo 3; D index 3 is dropped.
    for (int i = 0; i < 3; i++) a3_valid[i] = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 3;
`endif
      @(negedge clk);
      check($sformatf("n3 rr%0d source", k), 128'(dev_a3_source), 128'(exp_g * 5));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) a3_valid[i] = 1'b0;
    dev_d3_valid = 1'b1; dev_d3_source = 4'b1101;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("n3 drop host_d_valid%0d", i), 128'(host_d3_valid[i]), 128'(0));
    check("n3 drop dev_d_ready", 128'(dev_d3_ready), 128'(1));
    dev_d3_source = 4'b1010; host_d3_ready[2] = 1'b0;
    #1;
    check("n3 idx2 host_d_valid2", 128'(host_d3_valid[2]), 128'(1));
    check("n3 idx2 host_d_source2", 128'(host_d3_source[2]), 128'(2'b10));
    check("n3 idx2 dev_d_ready", 128'(dev_d3_ready), 128'(0));
    dev_d3_valid = 1'b0;

    // Random traffic against the model.
    @(posedge clk); #1;
    random_mode = 1'b1;
    randomize_inputs();
    for (int c = 0; c < 600; c++) cycle("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muntjac_tl_host_arbiter.md
# muntjac_tl_host_arbiter

Shares one TileLink uncached host port (A and D channels) between `NumHosts` requesters, such as several core uncached/MMIO ports or a core plus a debug host, ahead of the SoC crossbar. The arbitration policy is round-robin. A grant is held for every beat of a multi-beat A message. Each host index is prepended to the outgoing source ID, and the response is routed back to its host by those prepended source bits.

## Interface
Parameters:
- `NumHosts`, 2, number of requesters (≥2); `IdxWidth = $clog2(NumHosts)` is derived.
- `DataWidth`, 64, beat width in bits.
- `SizeWidth`, 3, width of TL size field.
- `SourceWidth`, 2, host-side source width; device side is `SourceWidth+IdxWidth`.
- `APayloadWidth`, 128, opaque A fields (address, param, mask, data, corrupt), passed through untouched.
- `DPayloadWidth`, 72, opaque D fields (param, sink, denied, data, corrupt), passed through untouched.

Ports (`[N]` = `NumHosts`-wide unpacked array):
- `clk_i`  in  1  clock; the block uses this single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `host_a_valid_i`  in  [N]  A valid per host.
- `host_a_ready_o`  out  [N]  A ready per host.
- `host_a_opcode_i`  in  [N]x3  A opcode.
- `host_a_size_i`  in  [N]xSizeWidth  log2 bytes.
- `host_a_source_i`  in  [N]xSourceWidth  host source ID.
- `host_a_payload_i`  in  [N]xAPayloadWidth  opaque A fields.
- `dev_a_valid_o` / `dev_a_ready_i`  out/in  1  device A handshake.
- `dev_a_opcode_o`, `dev_a_size_o`, `dev_a_payload_o`  out  as host  muxed from the granted host.
- `dev_a_source_o`  out  SourceWidth+IdxWidth  {grant index, host source}.
- `dev_d_valid_i` / `dev_d_ready_o`  in/out  1  device D handshake.
- `dev_d_opcode_i`, `dev_d_size_i`, `dev_d_source_i`, `dev_d_payload_i`  in  device D fields.
- `host_d_valid_o`  out  [N]  D valid, asserted only for the addressed host.
- `host_d_ready_i`  in  [N]  D ready.
- `host_d_opcode_o`, `host_d_size_o`, `host_d_payload_o`  out  broadcast copies of the device D fields.
- `host_d_source_o`  out  SourceWidth  `dev_d_source_i[SourceWidth-1:0]`.

## Operation
- Beat count for A: PutFullData (0) and PutPartialData (1) with `2^size > DataWidth/8` have `2^size/(DataWidth/8)` beats. Every other A message is 1 beat.
- FSM states are IDLE and LOCKED. The registers are `rr_ptr` (IdxWidth), `grant_q` (IdxWidth) and `beats_left` (SizeWidth+1).
- IDLE:
  - The grant is the first valid host at or after `rr_ptr`, wrapping modulo `NumHosts`. This grant is combinational.
  - If the first beat handshakes and the message is multi-beat: latch `grant_q`, set `beats_left = beats-1`, go to LOCKED.
  - If the message is single-beat: `rr_ptr <= grant+1` (wraps), stay in IDLE.
- LOCKED:
  - The grant is fixed to `grant_q`.
  - Each dev A handshake decrements `beats_left`.
  - On the handshake where `beats_left==1`: `rr_ptr <= grant_q+1`, go to IDLE.
  - Requests from other hosts are ignored until the burst completes.
- A path:
  - `dev_a_valid_o = host_a_valid_i[grant]` when any grant exists.
  - `host_a_ready_o[i] = dev_a_ready_i && (i==grant)`.
  - All A fields are muxed from the granted host.
- D path:
  - `idx = dev_d_source_i[SourceWidth+:IdxWidth]`.
  - `host_d_valid_o[i] = dev_d_valid_i && idx==i`.
  - `dev_d_ready_o = host_d_ready_i[idx]`.
  - The D path holds no state. Multi-beat D stays contiguous because the device never interleaves beats from different sources.
- An `idx ≥ NumHosts` on D is a protocol error. The block drops it: `dev_d_ready_o` = 1 and no `host_d_valid_o` is asserted.

## Timing
- Zero-latency combinational A and D paths; no data registers.
- The grant may change only in the cycle after a last-beat handshake. It never changes mid-burst, including while `dev_a_ready_i` is low.
- While the granted host holds `valid` and the device stalls, all `dev_a_*` fields stay stable.
- Reset values: IDLE, `rr_ptr=0`, `grant_q=0`, `beats_left=0`.
- While `rst_ni` is low, `dev_a_valid_o`, `host_a_ready_o`, `host_d_valid_o` and `dev_d_ready_o` are forced to 0.
- Reset asserted mid-burst aborts the lock immediately. Cleaning up the remaining beats is the responsibility of the system-wide reset.

## Configuration
- `TL_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest valid index wins in IDLE, and `rr_ptr` is removed. Burst locking is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- N=2, DataWidth=64:
  - Stimulus: both hosts issue a Get of size 3 from reset, with source 1 and 2.
  - Response: host0 is granted in cycle 0 with `dev_a_source_o=3'b001`, then host1 in cycle 1 with `3'b110`.
- Burst locking:
  - Stimulus: host1 sends PutFullData of size 5 (4 beats); host0 asserts valid at beat 2.
  - Response: host0 stays not-ready until host1's 4th beat handshakes, then is granted the next cycle.
- D routing:
  - Stimulus: device D arrives with source `3'b111` while `host_d_ready_i=2'b01`.
  - Response: only `host_d_valid_o[1]` is asserted with `host_d_source_o=2'b11`. `dev_d_ready_o=0` until host1 is ready.
- Device stall:
  - Stimulus: `dev_a_ready_i` is held low for 3 cycles during beat 2 of 4.
  - Response: `beats_left` is unchanged, the grant and payload are stable, and the burst completes after the 4 handshakes.
- Reset mid-burst:
  - Stimulus: `rst_ni` pulses low after beat 2 of 4.
  - Response: all outputs go to 0 during reset. After release the FSM is in IDLE, and a new Get from host1 is granted immediately.
- Fixed priority:
  - Stimulus: with `TL_ARB_FIXED_PRIO_EN`, host0 issues back-to-back Gets while host1 is valid.
  - Response: host1 is never granted. Without the macro, the grants alternate 0,1,0,1.
